vending_machine: RTL and testbench

- Single-product vending controller. The product price is 15 units.
- Accepts one coin code per clock, accumulates credit, and pulses `out` for one cycle when credit reaches or exceeds the price.
- Returns overpayment or refunded credit on `change`.
- Sits between the coin-acceptor front end and the dispense/return actuators. Both actuators consume single-cycle pulses.

---
 rtl/vending_machine_pkg.sv | 25 ++
 rtl/vending_machine.sv | 69 ++++++
 tb/tb_vending_machine.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vending_machine_pkg.sv
// Shared constants and types for the single-product vending controller.
// Coin and change encodings match the coin-acceptor and actuator interfaces.
package vending_machine_pkg;

  localparam int unsigned PRICE = 15;

  // Coin codes as presented on the 2-bit coin input.
  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_5      = 2'b01;
  localparam logic [1:0] COIN_10     = 2'b10;
  localparam logic [1:0] COIN_CANCEL = 2'b11;

  // Change codes; 2'b11 is reserved and never driven.
  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  // Stored credit: 0, 5 or 10 units.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    C5   = 2'd1,
    C10  = 2'd2
  } state_e;

endpackage

// File: rtl/vending_machine.sv
// Vending controller: accumulates 5/10 coins toward PRICE and emits registered
// single-cycle dispense and change pulses computed from (state, coin).
module vending_machine
  import vending_machine_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic       out,
  output logic [1:0] change
);

  state_e state_q;

  // Outputs default low on every edge so each pulse lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out     <= 1'b0;
      change  <= CHG_NONE;
    end else begin
      out    <= 1'b0;
      change <= CHG_NONE;
      case (state_q)
        IDLE: begin
          case (in)
            COIN_5:  state_q <= C5;
            COIN_10: state_q <= C10;
            default: state_q <= IDLE;
          endcase
        end
        C5: begin
          case (in)
            COIN_5:  state_q <= C10;
            COIN_10: begin
              state_q <= IDLE;
              out     <= 1'b1;
            end
            COIN_CANCEL: begin
              state_q <= IDLE;
              change  <= CHG_5;
            end
            default: state_q <= C5;
          endcase
        end
        C10: begin
          case (in)
            COIN_5: begin
              state_q <= IDLE;
              out     <= 1'b1;
            end
            COIN_10: begin
              state_q <= IDLE;
              out     <= 1'b1;
              change  <= CHG_5;
            end
            COIN_CANCEL: begin
              state_q <= IDLE;
              change  <= CHG_10;
            end
            default: state_q <= C10;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Randomized bench: an integer credit model predicts each cycle's out/change,
// a monitor pops predictions and compares them with the DUT one cycle later.
module tb_vending_machine;

  typedef struct packed {
    logic       o;
    logic [1:0] c;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       out;
  logic [1:0] change;

  int   checks;
  int   errors;
  exp_t exp_q[$];

  vending_machine dut (
    .clk    (clk),
    .rst    (rst),
    .in     (coin),
    .out    (out),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: credit in units, vend when credit reaches 15.
  initial begin
    int   credit;
    exp_t e;
    credit = 0;
    forever begin
      @(posedge clk);
      e = '0;
      if (rst) begin
        credit = 0;
      end else if (coin == 2'b11) begin
        e.c    = 2'(credit / 5);
        credit = 0;
      end else begin
        credit += (coin == 2'b01) ? 5 : (coin == 2'b10) ? 10 : 0;
        if (credit >= 15) begin
          e.o    = 1'b1;
          e.c    = 2'((credit - 15) / 5);
          credit = 0;
        end
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: outputs are valid every cycle, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (out !== e.o) begin
          errors++;
          $display("FAIL out at %0t: got %b expected %b", $time, out, e.o);
        end
        checks++;
        if (change !== e.c) begin
          errors++;
          $display("FAIL change at %0t: got %b expected %b", $time, change, e.c);
        end
      end
    end
  end

  task automatic step(input logic r, input logic [1:0] c);
    @(negedge clk);
    rst  = r;
    coin = c;
  endtask

  task automatic seq(input logic [1:0] coins[$]);
    step(1'b1, 2'b00);
    foreach (coins[i]) step(1'b0, coins[i]);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    coin   = 2'b00;
    step(1'b1, 2'b00);

    // Held 5-unit coin vends on every third edge.
    seq('{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01});
    seq('{2'b01, 2'b10});
    seq('{2'b10, 2'b10, 2'b00});
    seq('{2'b10, 2'b11});
    seq('{2'b01, 2'b11});
    seq('{2'b11, 2'b11});
    seq('{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01});

    // Reset while holding 10 credit with a coin on the same edge forfeits it.
    step(1'b1, 2'b00);
    step(1'b0, 2'b10);
    step(1'b1, 2'b01);
    step(1'b0, 2'b10);
    step(1'b0, 2'b00);
    step(1'b0, 2'b11);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)));
    end
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
